// File: rtl/cache_lookup_reader_if.sv
// Request/response handshake bundle between the command front-end and the cache lookup engine.
interface cache_lookup_reader_if #(
    parameter int KEY_WIDTH   = 64,
    parameter int VALUE_WIDTH = 64,
    parameter int TTL_WIDTH   = 32,
    parameter int IDX_WIDTH   = 3
);
    logic                   req_valid;
    logic                   req_ready;
    logic [KEY_WIDTH-1:0]   req_key;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_hit;
    logic [VALUE_WIDTH-1:0] rsp_value;
    logic [TTL_WIDTH-1:0]   rsp_ttl;
    logic [IDX_WIDTH-1:0]   rsp_index;

    modport master (
        output req_valid, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_value, rsp_ttl, rsp_index
    );

    modport slave (
        input  req_valid, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_value, rsp_ttl, rsp_index
    );
endinterface

// File: rtl/cache_lookup_reader.sv
// Read-side lookup engine: scans the cell bank one cell per cycle and returns the
// first valid cell whose key matches, or a miss.
//
// state | meaning
// IDLE  | ready for a request, req_ready high
// SCAN  | comparing cell at scan index against latched key
// RESP  | response held until consumer takes it
module cache_lookup_reader #(
    parameter int NUM_CELLS   = 8,
    parameter int KEY_WIDTH   = 64,
    parameter int VALUE_WIDTH = 64,
    parameter int TTL_WIDTH   = 32,
    parameter int STAT_WIDTH  = 16,
    localparam int IDX_WIDTH  = $clog2(NUM_CELLS)
) (
    input  logic                             clk,
    input  logic                             rst,
    cache_lookup_reader_if.slave             bus,
    input  logic [NUM_CELLS*KEY_WIDTH-1:0]   cell_key,
    input  logic [NUM_CELLS*VALUE_WIDTH-1:0] cell_value,
    input  logic [NUM_CELLS*TTL_WIDTH-1:0]   cell_ttl,
    input  logic [NUM_CELLS-1:0]             cell_valid,
    output logic [STAT_WIDTH-1:0]            hit_count,
    output logic [STAT_WIDTH-1:0]            miss_count
);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                 state;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [IDX_WIDTH-1:0]   idx;
    logic                   match;

    logic [KEY_WIDTH-1:0]   key_a   [NUM_CELLS];
    logic [VALUE_WIDTH-1:0] value_a [NUM_CELLS];
    logic [TTL_WIDTH-1:0]   ttl_a   [NUM_CELLS];

    always_comb begin
        for (int i = 0; i < NUM_CELLS; i++) begin
            key_a[i]   = cell_key[i*KEY_WIDTH +: KEY_WIDTH];
            value_a[i] = cell_value[i*VALUE_WIDTH +: VALUE_WIDTH];
            ttl_a[i]   = cell_ttl[i*TTL_WIDTH +: TTL_WIDTH];
        end
    end

    // Only the cell under the scan index is looked at; the rest of the bank may change freely.
    assign match = cell_valid[idx] && (key_a[idx] == key_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            key_q         <= '0;
            idx           <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_value <= '0;
            bus.rsp_ttl   <= '0;
            bus.rsp_index <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        key_q         <= bus.req_key;
                        idx           <= '0;
                        bus.req_ready <= 1'b0;
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (match) begin
                        bus.rsp_hit   <= 1'b1;
                        bus.rsp_value <= value_a[idx];
                        bus.rsp_ttl   <= ttl_a[idx];
                        bus.rsp_index <= idx;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (idx == IDX_WIDTH'(NUM_CELLS - 1)) begin
                        bus.rsp_hit   <= 1'b0;
                        bus.rsp_value <= '0;
                        bus.rsp_ttl   <= '0;
                        bus.rsp_index <= '0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        idx <= idx + IDX_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                        if (bus.rsp_hit) begin
                            if (hit_count != '1) hit_count <= hit_count + STAT_WIDTH'(1);
                        end else begin
                            if (miss_count != '1) miss_count <= miss_count + STAT_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cache_lookup_reader.md
# cache_lookup_reader

Read-side lookup engine for the key/value cache: accepts a key request over a valid/ready handshake, scans the bank of memory cells one cell per cycle, and returns the stored value, remaining TTL and cell index on hit, or a miss indication. It sits between the command front-end and the cell array, consuming the cells' continuously driven key/value/TTL/valid outputs; cell writes go through a separate path.

## Interface
- NUM_CELLS, 8, number of cells scanned (power of two, >= 2)
- KEY_WIDTH, 64, key width in bits
- VALUE_WIDTH, 64, value width in bits
- TTL_WIDTH, 32, TTL counter width in bits
- IDX_WIDTH, $clog2(NUM_CELLS), cell index width (derived, not overridden)
- STAT_WIDTH, 16, width of hit/miss statistics counters

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  lookup request present
- req_ready  out  1  engine can accept a request
- req_key  in  KEY_WIDTH  key to look up
- cell_key  in  NUM_CELLS*KEY_WIDTH  cell keys, cell i at bits [i*KEY_WIDTH +: KEY_WIDTH]
- cell_value  in  NUM_CELLS*VALUE_WIDTH  cell values, same packing
- cell_ttl  in  NUM_CELLS*TTL_WIDTH  cell remaining TTL, same packing
- cell_valid  in  NUM_CELLS  cell valid flags, bit i = cell i
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_hit  out  1  1 = key found in a valid cell
- rsp_value  out  VALUE_WIDTH  value of matching cell (0 on miss)
- rsp_ttl  out  TTL_WIDTH  TTL of matching cell at match cycle (0 on miss)
- rsp_index  out  IDX_WIDTH  index of matching cell (0 on miss)
- hit_count  out  STAT_WIDTH  completed hit responses, saturating
- miss_count  out  STAT_WIDTH  completed miss responses, saturating

## Operation
- FSM states: IDLE, SCAN, RESP.
- IDLE: req_ready=1. On req_valid&req_ready: latch req_key, clear scan index to 0, go SCAN.
- SCAN: req_ready=0. Each cycle compare cell at scan index: match = cell_valid[idx] && cell_key[idx]==latched key.
  - Match: capture value, ttl, idx into response registers, rsp_hit=1, go RESP.
  - No match, idx==NUM_CELLS-1: response registers zeroed, rsp_hit=0, go RESP.
  - Otherwise idx+1, stay SCAN.
- RESP: rsp_valid=1, all rsp_* held stable until rsp_valid&rsp_ready; on handshake increment hit_count or miss_count (saturate at all-ones, no wrap), go IDLE.
- Lowest matching index wins (scan order); later duplicates never examined.
- Cell inputs sampled only at the cycle their index is compared; a cell written or expired before/after its compare cycle does not affect the result. Response is a snapshot, unaffected by later cell changes.
- Invalid cell with matching key = no match. Key comparison is full-width equality.
- Scan index is IDX_WIDTH bits; never wraps during a scan.

## Timing
- Reset (rst=1 at a clk edge): state IDLE, req_ready=1 in the following cycle, rsp_valid=0, rsp_hit=0, rsp_value=0, rsp_ttl=0, rsp_index=0, hit_count=0, miss_count=0, latched key and scan index 0. Reset mid-SCAN or mid-RESP abandons the lookup; no counter update, no response.
- Request accepted at edge T0. Cell i compared in cycle after edge T0+i. Hit at cell i: rsp_valid=1 from edge T0+i+1 (latency i+2 cycles to visible response including accept cycle, i.e. cell 0 hit -> rsp_valid one cycle after accept cycle).
- Miss: rsp_valid asserted from edge T0+NUM_CELLS.
- Response handshake at edge T1 -> rsp_valid=0, req_ready=1 in the next cycle; next request accepted no earlier than edge T1+1. No overlap of requests.
- Counters update at the handshake edge, visible the next cycle.
- req_key changing while not in IDLE is ignored.

## Test plan
- Reset then cell 0 valid key 0xA, value 0x1234, ttl 50; request key 0xA -> rsp_valid one cycle after accept, rsp_hit=1, rsp_value=0x1234, rsp_ttl=50 (as sampled), rsp_index=0; hit_count=1 after handshake.
- All cells valid, none with key 0xFF; request 0xFF -> rsp_valid exactly NUM_CELLS cycles after accept, rsp_hit=0, rsp_value/ttl/index=0; miss_count=1.
- Key 0x5 in cells 3 and 6 (both valid) -> rsp_index=3, value of cell 3, response at accept+4 cycles.
- Cell 2 holds key 0x7 with cell_valid=0 -> miss; cell 5 valid key 0x7 clears cell_valid two cycles after its compare -> hit on 5 with original value held while rsp_ready=0 for 10 cycles.
- rsp_ready held low 20 cycles -> rsp_* stable, req_ready=0, further req_valid ignored; after handshake next request accepted one cycle later.
- rst asserted during SCAN of cell 4 -> next cycle rsp_valid=0, req_ready=1, counters 0; hit_count preloaded near max by 0xFFFF+2 hits saturates at 0xFFFF.
